// File: rtl/weather_pkg.sv
// rtl/weather_pkg.sv - shared defaults, FSM state type and quantiser for the weather feature encoder
package weather_pkg;

    localparam int RAW_W_DEF    = 8;
    localparam int FEAT_W_DEF   = 4;
    localparam int WIN_LOG2_DEF = 3;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    // Truncating quantiser; callers size-cast the result to the feature width.
    function automatic logic [31:0] quantise(input logic [31:0] value, input int shift);
        return value >> shift;
    endfunction

endpackage

// File: rtl/wx_window_accum.sv
// rtl/wx_window_accum.sv - window max/min/saturating-sum/sum registers with first-sample load
module wx_window_accum #(
    parameter int RAW_W    = 8,
    parameter int WIN_LOG2 = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      first,
    input  logic [RAW_W-1:0]          temp,
    input  logic [RAW_W-1:0]          precip,
    input  logic [RAW_W-1:0]          wind,
    output logic [RAW_W-1:0]          max_next,
    output logic [RAW_W-1:0]          min_next,
    output logic [RAW_W-1:0]          psum_next,
    output logic [RAW_W+WIN_LOG2-1:0] wsum_next
);

    logic [RAW_W-1:0]          max_q;
    logic [RAW_W-1:0]          min_q;
    logic [RAW_W-1:0]          psum_q;
    logic [RAW_W+WIN_LOG2-1:0] wsum_q;
    logic [RAW_W:0]            psum_ext;
    logic [RAW_W+WIN_LOG2-1:0] wind_ext;

    assign psum_ext = {1'b0, psum_q} + {1'b0, precip};
    assign wind_ext = {{WIN_LOG2{1'b0}}, wind};

    // The first sample of a window overwrites every register so nothing leaks across windows.
    always_comb begin
        max_next  = max_q;
        min_next  = min_q;
        psum_next = psum_q;
        wsum_next = wsum_q;
        if (first) begin
            max_next  = temp;
            min_next  = temp;
            psum_next = precip;
            wsum_next = wind_ext;
        end else begin
            max_next  = (temp > max_q) ? temp : max_q;
            min_next  = (temp < min_q) ? temp : min_q;
            psum_next = psum_ext[RAW_W] ? {RAW_W{1'b1}} : psum_ext[RAW_W-1:0];
            wsum_next = wsum_q + wind_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q  <= '0;
            min_q  <= '0;
            psum_q <= '0;
            wsum_q <= '0;
        end else if (load) begin
            max_q  <= max_next;
            min_q  <= min_next;
            psum_q <= psum_next;
            wsum_q <= wsum_next;
        end
    end

endmodule

// File: rtl/weather_feature_encoder.sv
// rtl/weather_feature_encoder.sv - reduces sample windows to four quantised features behind a valid/ready handshake
module weather_feature_encoder
    import weather_pkg::*;
#(
    parameter int RAW_W    = RAW_W_DEF,
    parameter int FEAT_W   = FEAT_W_DEF,
    parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic [RAW_W-1:0]  sample_temp,
    input  logic [RAW_W-1:0]  sample_precip,
    input  logic [RAW_W-1:0]  sample_wind,
    output logic              feat_valid,
    input  logic              feat_ready,
    output logic [FEAT_W-1:0] out_temp_max,
    output logic [FEAT_W-1:0] out_temp_min,
    output logic [FEAT_W-1:0] out_precipitation,
    output logic [FEAT_W-1:0] out_wind
);

    localparam int SHIFT = RAW_W - FEAT_W;

    state_t                    state;
    state_t                    next_state;
    logic [WIN_LOG2-1:0]       count;
    logic                      accept;
    logic                      last;
    logic                      first;
    logic [RAW_W-1:0]          max_next;
    logic [RAW_W-1:0]          min_next;
    logic [RAW_W-1:0]          psum_next;
    logic [RAW_W+WIN_LOG2-1:0] wsum_next;
    logic [RAW_W-1:0]          wind_mean;

    assign sample_ready = (state == ACCUM);
    assign feat_valid   = (state == EMIT);
    assign accept       = sample_valid & sample_ready;
    assign first        = (count == '0);
    assign last         = (count == {WIN_LOG2{1'b1}});
    assign wind_mean    = wsum_next[RAW_W+WIN_LOG2-1:WIN_LOG2];

    wx_window_accum #(
        .RAW_W    (RAW_W),
        .WIN_LOG2 (WIN_LOG2)
    ) u_accum (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .first     (first),
        .temp      (sample_temp),
        .precip    (sample_precip),
        .wind      (sample_wind),
        .max_next  (max_next),
        .min_next  (min_next),
        .psum_next (psum_next),
        .wsum_next (wsum_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ACCUM: if (accept && last) next_state = EMIT;
            EMIT:  if (feat_ready)     next_state = ACCUM;
            default:                   next_state = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (accept) begin
            count <= count + 1'b1;
        end
    end

    // Features are captured from the accumulator's next values so the last sample is included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_temp_max      <= '0;
            out_temp_min      <= '0;
            out_precipitation <= '0;
            out_wind          <= '0;
        end else if (accept && last) begin
            out_temp_max      <= FEAT_W'(quantise(32'(max_next), SHIFT));
            out_temp_min      <= FEAT_W'(quantise(32'(min_next), SHIFT));
            out_precipitation <= FEAT_W'(quantise(32'(psum_next), SHIFT));
            out_wind          <= FEAT_W'(quantise(32'(wind_mean), SHIFT));
        end
    end

endmodule

// File: tb/tb_weather_feature_encoder.sv
// tb/tb_weather_feature_encoder.sv - window-level model plus directed vectors for weather_feature_encoder
module tb_weather_feature_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic       sample_ready;
    logic [7:0] sample_temp = '0;
    logic [7:0] sample_precip = '0;
    logic [7:0] sample_wind = '0;
    logic       feat_valid;
    logic       feat_ready = 1'b1;
    logic [3:0] out_temp_max;
    logic [3:0] out_temp_min;
    logic [3:0] out_precipitation;
    logic [3:0] out_wind;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    weather_feature_encoder dut (
        .clk               (clk),
        .rst               (rst),
        .sample_valid      (sample_valid),
        .sample_ready      (sample_ready),
        .sample_temp       (sample_temp),
        .sample_precip     (sample_precip),
        .sample_wind       (sample_wind),
        .feat_valid        (feat_valid),
        .feat_ready        (feat_ready),
        .out_temp_max      (out_temp_max),
        .out_temp_min      (out_temp_min),
        .out_precipitation (out_precipitation),
        .out_wind          (out_wind)
    );

    // Window model: collect samples in arrays, reduce with plain arithmetic when full.
    int   win_t[$];
    int   win_p[$];
    int   win_w[$];
    bit   pending;
    int   exp_max, exp_min, exp_prec, exp_wind;

    task automatic reduce_window();
        int mx, mn, ps, ws;
        mx = 0; mn = 255; ps = 0; ws = 0;
        for (int i = 0; i < 8; i++) begin
            if (win_t[i] > mx) mx = win_t[i];
            if (win_t[i] < mn) mn = win_t[i];
            ps += win_p[i];
            ws += win_w[i];
        end
        if (ps > 255) ps = 255;
        exp_max  = mx / 16;
        exp_min  = mn / 16;
        exp_prec = ps / 16;
        exp_wind = (ws / 8) / 16;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            win_t.delete(); win_p.delete(); win_w.delete();
            pending = 1'b0;
            exp_max = 0; exp_min = 0; exp_prec = 0; exp_wind = 0;
        end else if (pending) begin
            if (feat_ready) pending = 1'b0;
        end else if (sample_valid) begin
            win_t.push_back(int'(sample_temp));
            win_p.push_back(int'(sample_precip));
            win_w.push_back(int'(sample_wind));
            if (win_t.size() == 8) begin
                reduce_window();
                win_t.delete(); win_p.delete(); win_w.delete();
                pending = 1'b1;
            end
        end
    end

    logic [17:0] act_bundle, exp_bundle;
    always @(negedge clk) begin
        act_bundle = {sample_ready, feat_valid, out_temp_max, out_temp_min, out_precipitation, out_wind};
        exp_bundle = {!pending, pending, 4'(exp_max), 4'(exp_min), 4'(exp_prec), 4'(exp_wind)};
        vectors++;
        if (act_bundle !== exp_bundle) begin
            errors++;
            $display("FAIL cycle_check t=%0t got rdy=%b vld=%b max=%h min=%h pr=%h wd=%h want rdy=%b vld=%b max=%h min=%h pr=%h wd=%h",
                     $time, act_bundle[17], act_bundle[16], act_bundle[15:12], act_bundle[11:8],
                     act_bundle[7:4], act_bundle[3:0], exp_bundle[17], exp_bundle[16],
                     exp_bundle[15:12], exp_bundle[11:8], exp_bundle[7:4], exp_bundle[3:0]);
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        vectors++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic send(input logic [7:0] t, input logic [7:0] p, input logic [7:0] w, input int gap);
        logic r;
        int   n;
        for (int g = 0; g < gap; g++) begin
            sample_valid = 1'b0;
            @(posedge clk); #1;
        end
        sample_valid  = 1'b1;
        sample_temp   = t;
        sample_precip = p;
        sample_wind   = w;
        n = 0;
        r = 1'b0;
        while (!r && n < 50) begin
            @(negedge clk);
            r = sample_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!r) begin
            errors++;
            $display("FAIL send_timeout got no accept want accept within 50 cycles");
        end
        sample_valid = 1'b0;
    endtask

    task automatic send_test1(input int gap);
        for (int i = 1; i <= 8; i++) send(8'(16 * i), 8'h10, 8'h40, gap);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        // reset state
        #2;
        check("reset_ready", {15'd0, sample_ready}, 16'h1);
        check("reset_outs", {out_temp_max, out_temp_min, out_precipitation, out_wind}, 16'h0000);
        idle(2);
        rst = 1'b0;
        idle(1);

        // 1: ramp temperature, feat_valid the cycle after the 8th accept
        send_test1(0);
        check("t1_valid", {15'd0, feat_valid}, 16'h1);
        check("t1_feats", {out_temp_max, out_temp_min, out_precipitation, out_wind}, 16'h8184);
        idle(2);

        // 2: precipitation saturates
        for (int i = 0; i < 8; i++) send(8'h50, 8'h40, 8'h88, 0);
        check("t2_feats", {out_temp_max, out_temp_min, out_precipitation, out_wind}, 16'h55F8);
        idle(2);

        // 3: backpressure holds the vector and refuses samples
        feat_ready = 1'b0;
        send_test1(0);
        sample_valid = 1'b1;
        sample_temp = 8'hEE; sample_precip = 8'hEE; sample_wind = 8'hEE;
        idle(5);
        check("t3_hold_valid", {15'd0, feat_valid}, 16'h1);
        check("t3_hold_ready", {15'd0, sample_ready}, 16'h0);
        check("t3_hold_feats", {out_temp_max, out_temp_min, out_precipitation, out_wind}, 16'h8184);
        sample_valid = 1'b0;
        feat_ready = 1'b1;
        idle(1);
        check("t3_released", {14'd0, feat_valid, sample_ready}, 16'h1);
        idle(1);

        // 4: reset mid-window discards the partial window
        for (int i = 0; i < 5; i++) send(8'hF0, 8'hF0, 8'hF0, 0);
        rst = 1'b1;
        idle(1);
        check("t4_reset_outs", {out_temp_max, out_temp_min, out_precipitation, out_wind}, 16'h0000);
        rst = 1'b0;
        idle(1);
        send_test1(0);
        check("t4_feats", {out_temp_max, out_temp_min, out_precipitation, out_wind}, 16'h8184);

        // 5: back-to-back windows with no carry-over
        send_test1(0);
        check("t5_w1_feats", {out_temp_max, out_temp_min, out_precipitation, out_wind}, 16'h8184);
        for (int i = 0; i < 8; i++) send(8'hF0, 8'h00, 8'h00, 0);
        check("t5_w2_feats", {out_temp_max, out_temp_min, out_precipitation, out_wind}, 16'hFF00);
        idle(2);

        // 6: gaps in sample_valid
        send_test1(1);
        check("t6_feats", {out_temp_max, out_temp_min, out_precipitation, out_wind}, 16'h8184);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
